armored40_tx_sched: RTL and testbench
=====================================

Name: armored40_tx_sched

Overview:
- Transmit-side scheduler for the armored 40-bit lane: scrambler → 40/33 ECC encoder → 2-word interleaver.
- Arbitrates between a 33-bit data requester and a control requester, and inserts idle and periodic sync words.
- Sequences scrambler reset and link training.
- Issues grants on interleaver pair boundaries only, so both words of an interleaved pair always come from one source.

Parameters:
- SCLR_CYCLES, 8: cycles enc_sclr is held after reset/restart (≥2).
- TRAIN_PAIRS, 16: sync pairs sent in TRAIN before RUN (≥1).
- SYNC_PERIOD, 1024: pairs between sync insertions in RUN (≥4).
- SYNC_PAT, 28'hA5C3F0F: sync payload.
- MAX_CTL_RUN, 4: consecutive control pairs allowed before one data pair is forced (≥1).

Ports:
- clk  in  1  single clock
- aclr_n  in  1  asynchronous active-low reset
- restart  in  1  synchronous pulse; re-enter scrambler reset
- dat_din  in  33  data word; bit 32 must be 0, forced to 0 on output
- dat_valid  in  1  data word available
- dat_ready  out  1  data word accepted this cycle (valid & ready)
- ctl_din  in  28  control payload
- ctl_valid  in  1  control word available
- ctl_ready  out  1  control word accepted this cycle
- enc_din  out  33  word to scrambler/encoder input
- enc_sclr  out  1  synchronous clear to scrambler/encoder/interleaver
- link_up  out  1  high in RUN
- sync_strobe  out  1  one-cycle pulse on the first word of each sync pair

Behaviour:
- Reset (aclr_n=0, asynchronous):
  - state=SCLR, counters=0, phase=0.
  - enc_din=IDLE, enc_sclr=1, dat_ready=0, ctl_ready=0, link_up=0, sync_strobe=0.
- Word encodings:
  - IDLE = {1'b1,4'h0,28'h0}
  - SYNC = {1'b1,4'hF,SYNC_PAT}
  - CTL = {1'b1,4'h1,ctl_din}
  - DATA = {1'b0,dat_din[31:0]}
- Outputs: all registered. A word accepted at cycle N (ready=1 combinationally with valid) appears on enc_din at N+1.
- Phase: a phase bit toggles every cycle while enc_sclr=0. Pair decisions are made only at phase=0. Phase is forced to 0 while enc_sclr=1.
- State SCLR:
  - enc_sclr=1, enc_din=IDLE.
  - After SCLR_CYCLES cycles, go to TRAIN with phase=0.
- State TRAIN:
  - Emit SYNC on every word; TRAIN_PAIRS pairs in total.
  - sync_strobe fires on each phase-0 word.
  - Then go to RUN and raise link_up.
- State RUN, decision at phase=0, in priority order:
  1. Sync counter reached SYNC_PERIOD: issue a SYNC pair, pulse sync_strobe, clear the counter.
  2. ctl_valid and ctl_run<MAX_CTL_RUN: grant CTL, ctl_run++.
  3. dat_valid: grant DATA, ctl_run=0.
  4. Otherwise: IDLE pair. ctl_run is cleared if ctl_valid=0.
- If ctl_run==MAX_CTL_RUN and dat_valid=0, CTL is granted anyway (no forced idle).
- The sync counter increments once per pair.
- The grant holds for both phases. If the granted source drops valid at phase=1, emit IDLE for that word; ready stays 0.
- ready is asserted only for the granted source in the cycle a word is taken. Never both.
- restart, or link loss via reset:
  - restart=1 in any state → next cycle state=SCLR, link_up=0.
  - Any in-flight pair is truncated: the second word is not taken.
  - restart held high keeps SCLR and its counter at 0.
- Simultaneous sync due and pending requests: sync wins; requesters wait one pair.
- A sync counter wrap during TRAIN has no effect; the counter is cleared on entry to RUN.

Decomposition:
- Shared package armored40_pkg: word-type nibble constants (IDLE 4'h0, CTL 4'h1, SYNC 4'hF), flag bit index 32, and a state enum {SCLR, TRAIN, RUN}.
- One natural sub-module: armored40_pair_arb (phase-0 priority/starvation arbiter with grant hold).
- The FSM, counters and output mux stay in the top module.

Test Plan:
- Reset release with SCLR_CYCLES=8, TRAIN_PAIRS=2:
  - enc_sclr high for cycles 0-7.
  - Then 4 SYNC words (1,F,A5C3F0F) with sync_strobe on words 0 and 2.
  - link_up rises at cycle 12; idle pairs follow.
- Continuous dat_valid in RUN with SYNC_PERIOD=4:
  - Pattern is 4 data pairs, then one SYNC pair.
  - dat_ready low exactly 2 cycles per period.
  - Data word x appears on enc_din one cycle after acceptance with bit 32=0.
- ctl_valid and dat_valid both held with MAX_CTL_RUN=2: repeating CTL,CTL,DATA pair sequence; ctl_ready and dat_ready never both high.
- dat_valid rises at phase=1: no acceptance that cycle; granted at the next phase 0; previous pair is IDLE,IDLE.
- Granted source drops valid after the first word: second word is IDLE, no ready on phase 1, next decision proceeds normally.
- restart pulse mid-pair in RUN: link_up=0 and enc_sclr=1 the next cycle; second word not taken; full SCLR/TRAIN sequence repeats. An aclr_n assertion mid-TRAIN immediately gives the reset output values.

Source files
------------

// File: rtl/armored40_pkg.sv
// armored40_pkg
// Shared definitions for the armored 40-bit lane transmit scheduler:
// word-type nibbles, the flag bit position of a 33-bit lane word, the
// scheduler state enum and the pair-grant enum.
package armored40_pkg;

   localparam int unsigned FLAG_BIT  = 32;
   localparam logic [3:0]  TYPE_IDLE = 4'h0;
   localparam logic [3:0]  TYPE_CTL  = 4'h1;
   localparam logic [3:0]  TYPE_SYNC = 4'hF;

   typedef enum logic [1:0] {SCLR, TRAIN, RUN} state_t;
   typedef enum logic [1:0] {GNT_NONE, GNT_SYNC, GNT_CTL, GNT_DAT} gnt_t;

   // Flagged (non-data) lane word: flag bit, type nibble, 28-bit payload.
   function automatic logic [32:0] flagged_word(input logic [3:0]  kind,
                                                input logic [27:0] payload);
      return {1'b1, kind, payload};
   endfunction

endpackage

// File: rtl/armored40_pair_arb.sv
// armored40_pair_arb
// Pair-boundary arbiter. At phase 0 it picks SYNC / CTL / DATA / none by
// priority, limiting consecutive CTL pairs to MAX_CTL_RUN while data waits,
// and holds that grant for the phase-1 word.
// Ports:
//   clk, aclr_n          clock, asynchronous active-low reset
//   active               scheduler in RUN and not restarting
//   phase                0 = first word of a pair (decision point)
//   sync_due             a sync pair must be issued at this decision
//   dat_valid, ctl_valid requester valids
//   gnt                  source owning the current word
//   dat_ready, ctl_ready word taken from that requester this cycle
module armored40_pair_arb
   import armored40_pkg::*;
#(
   parameter int unsigned MAX_CTL_RUN = 4
) (
   input  logic clk,
   input  logic aclr_n,
   input  logic active,
   input  logic phase,
   input  logic sync_due,
   input  logic dat_valid,
   input  logic ctl_valid,
   output gnt_t gnt,
   output logic dat_ready,
   output logic ctl_ready
);

   localparam int unsigned      RUN_W   = $clog2(MAX_CTL_RUN + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_CTL_RUN);

   gnt_t             gnt_q, gnt_d;
   logic [RUN_W-1:0] run_q, run_d;

   always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
         gnt_q <= GNT_NONE;
         run_q <= '0;
      end else begin
         gnt_q <= gnt_d;
         run_q <= run_d;
      end
   end

   always_comb begin
      gnt   = GNT_NONE;
      gnt_d = GNT_NONE;
      run_d = run_q;
      if (!active) begin
         run_d = '0;
      end else if (!phase) begin
         if (sync_due) begin
            gnt = GNT_SYNC;
         end else if (ctl_valid && ((run_q < RUN_MAX) || !dat_valid)) begin
            // Past the run limit CTL still wins when no data is waiting;
            // the count saturates so the next data request is served first.
            gnt = GNT_CTL;
            if (run_q != RUN_MAX) run_d = run_q + RUN_W'(1);
         end else if (dat_valid) begin
            gnt   = GNT_DAT;
            run_d = '0;
         end else begin
            run_d = '0;
         end
         gnt_d = gnt;
      end else begin
         gnt = gnt_q;
      end
   end

   assign dat_ready = (gnt == GNT_DAT) && dat_valid;
   assign ctl_ready = (gnt == GNT_CTL) && ctl_valid;

endmodule

// File: rtl/armored40_tx_sched.sv
// armored40_tx_sched
// Transmit scheduler for the armored 40-bit lane. Sequences scrambler clear
// and link training, then arbitrates data/control requesters on interleaver
// pair boundaries and inserts periodic sync pairs. All lane outputs are
// registered; ready outputs are combinational with valid.
// Ports:
//   clk, aclr_n               clock, asynchronous active-low reset
//   restart                   synchronous pulse, re-enter scrambler clear
//   dat_din/valid/ready       33-bit data requester (bit 32 forced to 0)
//   ctl_din/valid/ready       28-bit control requester
//   enc_din                   word to the scrambler/encoder
//   enc_sclr                  synchronous clear to scrambler/encoder/interleaver
//   link_up                   high while in RUN
//   sync_strobe               pulse on the first word of each sync pair
module armored40_tx_sched
   import armored40_pkg::*;
#(
   parameter int unsigned SCLR_CYCLES = 8,
   parameter int unsigned TRAIN_PAIRS = 16,
   parameter int unsigned SYNC_PERIOD = 1024,
   parameter logic [27:0] SYNC_PAT    = 28'hA5C3F0F,
   parameter int unsigned MAX_CTL_RUN = 4
) (
   input  logic        clk,
   input  logic        aclr_n,
   input  logic        restart,
   input  logic [32:0] dat_din,
   input  logic        dat_valid,
   output logic        dat_ready,
   input  logic [27:0] ctl_din,
   input  logic        ctl_valid,
   output logic        ctl_ready,
   output logic [32:0] enc_din,
   output logic        enc_sclr,
   output logic        link_up,
   output logic        sync_strobe
);

   localparam int unsigned SCLR_W  = $clog2(SCLR_CYCLES);
   localparam int unsigned TRAIN_W = $clog2(TRAIN_PAIRS + 1);
   localparam int unsigned SYNC_W  = $clog2(SYNC_PERIOD + 1);

   // The reset value of enc_sclr covers the first clear cycle, so the
   // counter leaves SCLR one cycle early to hold enc_sclr SCLR_CYCLES long.
   localparam logic [SCLR_W-1:0]  SCLR_LAST  = SCLR_W'(SCLR_CYCLES - 2);
   localparam logic [TRAIN_W-1:0] TRAIN_LAST = TRAIN_W'(TRAIN_PAIRS - 1);
   localparam logic [SYNC_W-1:0]  SYNC_DUE   = SYNC_W'(SYNC_PERIOD);

   localparam logic [32:0] IDLE_WORD = {1'b1, TYPE_IDLE, 28'h0};
   localparam logic [32:0] SYNC_WORD = {1'b1, TYPE_SYNC, SYNC_PAT};

   state_t              state_q, state_d;
   logic                phase_q, phase_d;
   logic [SCLR_W-1:0]   sclr_cnt_q, sclr_cnt_d;
   logic [TRAIN_W-1:0]  train_cnt_q, train_cnt_d;
   logic [SYNC_W-1:0]   sync_cnt_q, sync_cnt_d;
   logic [32:0]         enc_din_d;
   logic                enc_sclr_d, link_up_d, sync_strobe_d;
   logic                run_active, sync_due;
   gnt_t                gnt;
   logic                unused_dat_flag;

   assign unused_dat_flag = dat_din[FLAG_BIT];
   assign run_active      = (state_q == RUN) && !restart;
   assign sync_due        = (sync_cnt_q == SYNC_DUE);

   armored40_pair_arb #(
      .MAX_CTL_RUN(MAX_CTL_RUN)
   ) u_arb (
      .clk       (clk),
      .aclr_n    (aclr_n),
      .active    (run_active),
      .phase     (phase_q),
      .sync_due  (sync_due),
      .dat_valid (dat_valid),
      .ctl_valid (ctl_valid),
      .gnt       (gnt),
      .dat_ready (dat_ready),
      .ctl_ready (ctl_ready)
   );

   always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
         state_q     <= SCLR;
         phase_q     <= 1'b0;
         sclr_cnt_q  <= '0;
         train_cnt_q <= '0;
         sync_cnt_q  <= '0;
         enc_din     <= IDLE_WORD;
         enc_sclr    <= 1'b1;
         link_up     <= 1'b0;
         sync_strobe <= 1'b0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         sclr_cnt_q  <= sclr_cnt_d;
         train_cnt_q <= train_cnt_d;
         sync_cnt_q  <= sync_cnt_d;
         enc_din     <= enc_din_d;
         enc_sclr    <= enc_sclr_d;
         link_up     <= link_up_d;
         sync_strobe <= sync_strobe_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      phase_d       = 1'b0;
      sclr_cnt_d    = sclr_cnt_q;
      train_cnt_d   = train_cnt_q;
      sync_cnt_d    = sync_cnt_q;
      enc_din_d     = IDLE_WORD;
      enc_sclr_d    = 1'b0;
      link_up_d     = 1'b0;
      sync_strobe_d = 1'b0;
      if (restart) begin
         state_d     = SCLR;
         sclr_cnt_d  = '0;
         train_cnt_d = '0;
         sync_cnt_d  = '0;
         enc_sclr_d  = 1'b1;
      end else begin
         case (state_q)
            SCLR: begin
               enc_sclr_d = 1'b1;
               if (sclr_cnt_q == SCLR_LAST) begin
                  state_d    = TRAIN;
                  sclr_cnt_d = '0;
               end else begin
                  sclr_cnt_d = sclr_cnt_q + SCLR_W'(1);
               end
            end
            TRAIN: begin
               phase_d       = ~phase_q;
               enc_din_d     = SYNC_WORD;
               sync_strobe_d = ~phase_q;
               if (phase_q) begin
                  if (train_cnt_q == TRAIN_LAST) begin
                     state_d     = RUN;
                     train_cnt_d = '0;
                     sync_cnt_d  = '0;
                  end else begin
                     train_cnt_d = train_cnt_q + TRAIN_W'(1);
                  end
               end
            end
            RUN: begin
               phase_d   = ~phase_q;
               link_up_d = 1'b1;
               if (!phase_q) sync_cnt_d = sync_due ? '0 : sync_cnt_q + SYNC_W'(1);
               case (gnt)
                  GNT_SYNC: begin
                     enc_din_d     = SYNC_WORD;
                     sync_strobe_d = ~phase_q;
                  end
                  GNT_CTL: if (ctl_ready) enc_din_d = flagged_word(TYPE_CTL, ctl_din);
                  GNT_DAT: if (dat_ready) enc_din_d = {1'b0, dat_din[31:0]};
                  default: ;
               endcase
            end
            default: state_d = SCLR;
         endcase
      end
   end

endmodule

// File: tb/tb_armored40_tx_sched.sv
// tb_armored40_tx_sched
// Self-checking bench for armored40_tx_sched with a cycle-level reference
// model derived from elapsed time since clear (clear/train/run windows,
// pair index modulo the sync period) and a history of granted pairs.
module tb_armored40_tx_sched;

   localparam int unsigned SCLR_C  = 8;
   localparam int unsigned TRAIN_P = 2;
   localparam int unsigned SYNC_P  = 4;
   localparam int unsigned MAX_RUN = 2;
   localparam logic [27:0] PAT     = 28'hA5C3F0F;
   localparam logic [32:0] W_IDLE  = {1'b1, 4'h0, 28'h0};
   localparam logic [32:0] W_SYNC  = {1'b1, 4'hF, PAT};
   // Cycle (counted from clear start) whose word is the first SYNC / first RUN word.
   localparam int unsigned TRAIN_START = SCLR_C - 1;
   localparam int unsigned RUN_START   = TRAIN_START + 2 * TRAIN_P;
   localparam int SRC_IDLE = 0;
   localparam int SRC_CTL  = 1;
   localparam int SRC_DAT  = 2;

   logic        clk = 1'b0;
   logic        aclr_n, restart, dat_valid, ctl_valid;
   logic [32:0] dat_din;
   logic [27:0] ctl_din;
   logic        dat_ready, ctl_ready, enc_sclr, link_up, sync_strobe;
   logic [32:0] enc_din;

   int unsigned checks = 0;
   int unsigned errors = 0;

   int unsigned age = 0;
   int          hist[$];
   int          cur_src = SRC_IDLE;
   int          dec_src = SRC_IDLE;
   bit          decided = 0;
   logic        e_dr, e_cr, e_sclr, e_link, e_strobe;
   logic [32:0] e_word;
   logic        obs_dr;

   armored40_tx_sched #(
      .SCLR_CYCLES (SCLR_C),
      .TRAIN_PAIRS (TRAIN_P),
      .SYNC_PERIOD (SYNC_P),
      .SYNC_PAT    (PAT),
      .MAX_CTL_RUN (MAX_RUN)
   ) dut (
      .clk         (clk),
      .aclr_n      (aclr_n),
      .restart     (restart),
      .dat_din     (dat_din),
      .dat_valid   (dat_valid),
      .dat_ready   (dat_ready),
      .ctl_din     (ctl_din),
      .ctl_valid   (ctl_valid),
      .ctl_ready   (ctl_ready),
      .enc_din     (enc_din),
      .enc_sclr    (enc_sclr),
      .link_up     (link_up),
      .sync_strobe (sync_strobe)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int unsigned trailing_ctl();
      int unsigned n = 0;
      for (int i = hist.size() - 1; i >= 0; i--) begin
         if (hist[i] != SRC_CTL) break;
         n++;
      end
      return n;
   endfunction

   // True when the upcoming cycle is phase ph of a non-sync RUN pair.
   function automatic bit model_at(input int unsigned ph);
      int unsigned rw;
      if (age < RUN_START) return 1'b0;
      rw = age - RUN_START;
      return ((rw % 2) == ph) && (((rw / 2) % (SYNC_P + 1)) != SYNC_P);
   endfunction

   task automatic predict();
      int unsigned rw, pair, ph;
      int          src;
      e_dr = 1'b0; e_cr = 1'b0; e_word = W_IDLE; e_sclr = 1'b0;
      e_link = 1'b0; e_strobe = 1'b0; decided = 0; src = SRC_IDLE;
      if (restart) begin
         e_sclr = 1'b1;
      end else if (age < TRAIN_START) begin
         e_sclr = 1'b1;
      end else if (age < RUN_START) begin
         e_word   = W_SYNC;
         e_strobe = ((age - TRAIN_START) % 2) == 0;
      end else begin
         rw = age - RUN_START; ph = rw % 2; pair = rw / 2; e_link = 1'b1;
         if ((pair % (SYNC_P + 1)) == SYNC_P) begin
            e_word   = W_SYNC;
            e_strobe = (ph == 0);
         end else begin
            if (ph == 0) begin
               if (ctl_valid && ((trailing_ctl() < MAX_RUN) || !dat_valid)) src = SRC_CTL;
               else if (dat_valid) src = SRC_DAT;
               else src = SRC_IDLE;
               dec_src = src;
               decided = 1;
            end else begin
               src = cur_src;
            end
            if (src == SRC_CTL && ctl_valid) begin
               e_cr = 1'b1; e_word = {1'b1, 4'h1, ctl_din};
            end
            if (src == SRC_DAT && dat_valid) begin
               e_dr = 1'b1; e_word = {1'b0, dat_din[31:0]};
            end
         end
      end
   endtask

   task automatic advance();
      if (restart) begin
         age = 0; hist.delete(); cur_src = SRC_IDLE;
      end else begin
         if (decided) begin
            hist.push_back(dec_src);
            if (hist.size() > 8) void'(hist.pop_front());
            cur_src = dec_src;
         end
         age++;
      end
   endtask

   // Called at a falling edge; drives inputs, checks ready, then the registered word.
   task automatic cycle(input logic dv, input logic [32:0] dd, input logic cv,
                        input logic [27:0] cd, input logic rs);
      dat_valid = dv; dat_din = dd; ctl_valid = cv; ctl_din = cd; restart = rs;
      #1;
      predict();
      obs_dr = dat_ready;
      chk("dat_ready", 33'(dat_ready), 33'(e_dr));
      chk("ctl_ready", 33'(ctl_ready), 33'(e_cr));
      chk("both_ready", 33'(dat_ready & ctl_ready), 33'(0));
      @(posedge clk);
      #1;
      chk("enc_din", enc_din, e_word);
      chk("enc_sclr", 33'(enc_sclr), 33'(e_sclr));
      chk("link_up", 33'(link_up), 33'(e_link));
      chk("sync_strobe", 33'(sync_strobe), 33'(e_strobe));
      advance();
      @(negedge clk);
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, '0, 1'b0);
   endtask

   task automatic align(input int unsigned ph);
      for (int unsigned i = 0; i < 16; i++) begin
         if (model_at(ph)) break;
         cycle(1'b0, '0, 1'b0, '0, 1'b0);
      end
   endtask

   task automatic check_reset_values();
      chk("rst_enc_din", enc_din, W_IDLE);
      chk("rst_enc_sclr", 33'(enc_sclr), 33'(1));
      chk("rst_link_up", 33'(link_up), 33'(0));
      chk("rst_sync_strobe", 33'(sync_strobe), 33'(0));
      chk("rst_dat_ready", 33'(dat_ready), 33'(0));
      chk("rst_ctl_ready", 33'(ctl_ready), 33'(0));
   endtask

   function automatic logic [32:0] rand_word();
      logic [32:0] w;
      w[31:0] = $urandom();
      w[32]   = 1'($urandom_range(0, 1));
      return w;
   endfunction

   initial begin
      int unsigned lows;
      aclr_n = 1'b0; restart = 1'b0; dat_valid = 1'b0; ctl_valid = 1'b0;
      dat_din = '0; ctl_din = '0;
      @(negedge clk);
      #1;
      check_reset_values();
      @(negedge clk);
      aclr_n = 1'b1;

      // Clear, training and first idle pairs.
      idle(20);

      // Continuous data: two sync pairs (4 idle-ready cycles) per 20 cycles.
      for (int unsigned i = 0; i < 10; i++) cycle(1'b1, rand_word(), 1'b0, '0, 1'b0);
      lows = 0;
      for (int unsigned i = 0; i < 20; i++) begin
         cycle(1'b1, rand_word(), 1'b0, '0, 1'b0);
         if (!obs_dr) lows++;
      end
      chk("dat_ready_low_2periods", 33'(lows), 33'(4));

      // Both requesters held: CTL,CTL,DATA repeating.
      for (int unsigned i = 0; i < 30; i++)
         cycle(1'b1, rand_word(), 1'b1, 28'($urandom()), 1'b0);

      // Data valid rises at phase 1.
      idle(2);
      align(1);
      for (int unsigned i = 0; i < 4; i++) cycle(1'b1, rand_word(), 1'b0, '0, 1'b0);

      // Granted source drops valid after the first word (data, then control).
      align(0);
      cycle(1'b1, rand_word(), 1'b0, '0, 1'b0);
      cycle(1'b0, rand_word(), 1'b0, '0, 1'b0);
      cycle(1'b1, rand_word(), 1'b0, '0, 1'b0);
      cycle(1'b1, rand_word(), 1'b0, '0, 1'b0);
      align(0);
      cycle(1'b0, '0, 1'b1, 28'($urandom()), 1'b0);
      cycle(1'b0, '0, 1'b0, 28'($urandom()), 1'b0);
      idle(2);

      // Restart mid-pair, held a few cycles, then full clear/train again.
      align(0);
      cycle(1'b1, rand_word(), 1'b0, '0, 1'b0);
      cycle(1'b1, rand_word(), 1'b0, '0, 1'b1);
      cycle(1'b1, rand_word(), 1'b1, 28'($urandom()), 1'b1);
      cycle(1'b0, '0, 1'b0, '0, 1'b1);
      idle(9);

      // Asynchronous reset in the middle of training.
      #2;
      aclr_n = 1'b0;
      #1;
      check_reset_values();
      age = 0; hist.delete(); cur_src = SRC_IDLE;
      @(negedge clk);
      @(negedge clk);
      aclr_n = 1'b1;
      idle(15);

      // Random traffic with occasional restarts.
      for (int unsigned i = 0; i < 400; i++)
         cycle(1'($urandom_range(0, 1)), rand_word(), 1'($urandom_range(0, 1)),
               28'($urandom()), 1'($urandom_range(0, 99) == 0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
